// File: rtl/ped_pkg.sv
// Shared definitions for the multi-channel edge-detector bank:
// the mode encoding and the default parameter values.
package ped_pkg;

    typedef enum logic [1:0] {
        PED_MODE_RISE = 2'b00,
        PED_MODE_FALL = 2'b01,
        PED_MODE_BOTH = 2'b10,
        PED_MODE_OFF  = 2'b11
    } ped_mode_e;

    localparam int PED_CH_DEFAULT          = 4;
    localparam int PED_SYNC_STAGES_DEFAULT = 2;
    localparam int PED_DB_CYCLES_DEFAULT   = 4;

endpackage

// File: rtl/ped_channel.sv
// One channel of the bank: synchroniser, debounce filter, mode-qualified
// one-cycle edge pulse and a sticky pending flag with clear.
module ped_channel
    import ped_pkg::*;
#(
    parameter int SYNC_STAGES = PED_SYNC_STAGES_DEFAULT,
    parameter int DB_CYCLES   = PED_DB_CYCLES_DEFAULT,
    parameter int DB_W        = $clog2(DB_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       ped,
    output logic       level,
    output logic       pending,
    output logic       pending_next
);

    logic [SYNC_STAGES-1:0] sync;
    logic [DB_W-1:0]        cnt;
    logic                   s;
    logic                   differ;
    logic                   toggle;
    logic                   qualified;
    logic                   ped_next;

    assign s      = sync[SYNC_STAGES-1];
    assign differ = (s != level);
    // The level flips on the DB_CYCLES-th consecutive differing sample, so cnt
    // never climbs past DB_CYCLES-1; with DB_CYCLES=1 it stays at zero.
    assign toggle = differ && (cnt == DB_W'(DB_CYCLES - 1));

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        qualified = 1'b0;
        case (mode)
            PED_MODE_RISE: qualified = ~level;  // old level 0 means the new level is 1
            PED_MODE_FALL: qualified = level;
            PED_MODE_BOTH: qualified = 1'b1;
            default:       qualified = 1'b0;
        endcase
    end

    assign ped_next     = toggle && qualified;
    // Set wins over a simultaneous clear.
    assign pending_next = ped_next | (pending & ~clr);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync    <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            ped     <= 1'b0;
            pending <= 1'b0;
        end else begin
            sync[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync[k] <= sync[k-1];
            end

            if (!differ) begin
                cnt <= '0;
            end else if (toggle) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + DB_W'(1);
            end

            ped     <= ped_next;
            pending <= pending_next;
        end
    end

endmodule

// File: rtl/ped_bank.sv
// Bank of CH independent debounced edge detectors sharing one mode select,
// plus a registered summary flag aligned with the pending outputs.
module ped_bank
    import ped_pkg::*;
#(
    parameter int CH          = PED_CH_DEFAULT,
    parameter int SYNC_STAGES = PED_SYNC_STAGES_DEFAULT,
    parameter int DB_CYCLES   = PED_DB_CYCLES_DEFAULT,
    parameter int DB_W        = $clog2(DB_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] Din,
    input  logic [1:0]    mode,
    input  logic [CH-1:0] clr,
    output logic [CH-1:0] ped,
    output logic [CH-1:0] level,
    output logic [CH-1:0] pending,
    output logic          any_pending
);

    logic [CH-1:0] pending_next;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        ped_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .DB_W        (DB_W)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .din          (Din[i]),
            .mode         (mode),
            .clr          (clr[i]),
            .ped          (ped[i]),
            .level        (level[i]),
            .pending      (pending[i]),
            .pending_next (pending_next[i])
        );
    end

    // Reduce the next-state vector so the flag lands on the same edge as pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            any_pending <= 1'b0;
        end else begin
            any_pending <= |pending_next;
        end
    end

endmodule

// File: tb/tb_ped_bank.sv
// Directed bench for ped_bank: a default-parameter bank plus a minimal
// CH=1 / SYNC_STAGES=1 / DB_CYCLES=1 instance sharing the clock and reset.
module tb_ped_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] din;
    logic [1:0] mode;
    logic [3:0] clr;
    logic [3:0] ped;
    logic [3:0] level;
    logic [3:0] pending;
    logic       any_pending;

    logic [0:0] din2;
    logic [1:0] mode2;
    logic [0:0] clr2;
    logic [0:0] ped2;
    logic [0:0] level2;
    logic [0:0] pending2;
    logic       any_pending2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ped_bank dut (
        .clk         (clk),
        .reset       (reset),
        .Din         (din),
        .mode        (mode),
        .clr         (clr),
        .ped         (ped),
        .level       (level),
        .pending     (pending),
        .any_pending (any_pending)
    );

    ped_bank #(
        .CH          (1),
        .SYNC_STAGES (1),
        .DB_CYCLES   (1)
    ) dut_min (
        .clk         (clk),
        .reset       (reset),
        .Din         (din2),
        .mode        (mode2),
        .clr         (clr2),
        .ped         (ped2),
        .level       (level2),
        .pending     (pending2),
        .any_pending (any_pending2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        din   = 4'b0000;
        mode  = 2'b00;
        clr   = 4'b0000;
        din2  = 1'b0;
        mode2 = 2'b10;
        clr2  = 1'b0;
        cyc(2);
        reset = 1'b0;
        check("reset_level",   32'(level),       32'h0);
        check("reset_ped",     32'(ped),         32'h0);
        check("reset_pending", 32'(pending),     32'h0);
        check("reset_any",     32'(any_pending), 32'h0);

        // 1: rising step on channel 0 lands on the 6th edge
        din = 4'b0001;
        cyc(5);
        check("t1_level_e4", 32'(level), 32'h0);
        check("t1_ped_e4",   32'(ped),   32'h0);
        cyc(1);
        check("t1_level_e5",   32'(level),       32'h1);
        check("t1_ped_e5",     32'(ped),         32'h1);
        check("t1_pending_e5", 32'(pending),     32'h1);
        check("t1_any_e5",     32'(any_pending), 32'h1);
        cyc(1);
        check("t1_ped_e6",     32'(ped),     32'h0);
        check("t1_pending_e6", 32'(pending), 32'h1);
        clr = 4'b0001;
        cyc(1);
        clr = 4'b0000;
        check("t1_clr_pending", 32'(pending),     32'h0);
        check("t1_clr_any",     32'(any_pending), 32'h0);

        // 2: three-sample glitch on channel 1 is filtered out
        din = 4'b0011;
        cyc(3);
        din = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            check("t2_level", 32'(level),   32'h1);
            check("t2_ped",   32'(ped),     32'h0);
            check("t2_pend",  32'(pending), 32'h0);
        end

        // 3: channel 2 under fall, both, then off
        mode = 2'b01;
        din  = 4'b0101;
        cyc(6);
        check("t3_fall_rise_level", 32'(level), 32'h5);
        check("t3_fall_rise_ped",   32'(ped),   32'h0);
        cyc(14);
        din = 4'b0001;
        cyc(5);
        check("t3_fall_level_pre", 32'(level), 32'h5);
        cyc(1);
        check("t3_fall_level", 32'(level), 32'h1);
        check("t3_fall_ped",   32'(ped),   32'h4);

        mode = 2'b10;
        din  = 4'b0101;
        cyc(6);
        check("t3_both_rise_ped", 32'(ped), 32'h4);
        cyc(1);
        check("t3_both_rise_done", 32'(ped), 32'h0);
        cyc(12);
        check("t3_both_gap_ped", 32'(ped), 32'h0);
        din = 4'b0001;
        cyc(5);
        check("t3_both_gap_ped2", 32'(ped), 32'h0);
        cyc(1);
        check("t3_both_fall_ped", 32'(ped), 32'h4);

        mode = 2'b11;
        din  = 4'b0101;
        cyc(6);
        check("t3_off_rise_level", 32'(level), 32'h5);
        check("t3_off_rise_ped",   32'(ped),   32'h0);
        din = 4'b0001;
        cyc(6);
        check("t3_off_fall_level", 32'(level),   32'h1);
        check("t3_off_fall_ped",   32'(ped),     32'h0);
        check("t3_off_pending",    32'(pending), 32'h4);
        clr = 4'b0100;
        cyc(1);
        clr = 4'b0000;
        check("t3_clr_pending", 32'(pending), 32'h0);

        // 4: clear on the set edge loses, clear on the next edge wins
        mode = 2'b00;
        din  = 4'b1001;
        cyc(5);
        clr = 4'b1000;
        cyc(1);
        check("t4_ped",     32'(ped),         32'h8);
        check("t4_pending", 32'(pending),     32'h8);
        check("t4_any",     32'(any_pending), 32'h1);
        cyc(1);
        clr = 4'b0000;
        check("t4_clr_pending", 32'(pending),     32'h0);
        check("t4_clr_any",     32'(any_pending), 32'h0);

        // 5: reset two counts into a channel-0 debounce
        din = 4'b1000;
        cyc(6);
        check("t5_level_low", 32'(level), 32'h8);
        din = 4'b1001;
        cyc(4);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("t5_rst_level",   32'(level),       32'h0);
        check("t5_rst_ped",     32'(ped),         32'h0);
        check("t5_rst_pending", 32'(pending),     32'h0);
        check("t5_rst_any",     32'(any_pending), 32'h0);
        check("t5_rst_level2",  32'(level2),      32'h0);
        cyc(5);
        check("t5_ped_e4", 32'(ped), 32'h0);
        cyc(1);
        check("t5_ped_e5",   32'(ped),   32'h9);
        check("t5_level_e5", 32'(level), 32'h9);

        // 6: minimal instance, both edges, latency of one edge
        din2 = 1'b1;
        cyc(1);
        check("t6_level_e0", 32'(level2), 32'h0);
        check("t6_ped_e0",   32'(ped2),   32'h0);
        cyc(1);
        check("t6_level_e1", 32'(level2),   32'h1);
        check("t6_ped_e1",   32'(ped2),     32'h1);
        check("t6_any_e1",   32'(any_pending2), 32'h1);
        for (int k = 0; k < 4; k++) begin
            din2 = ~din2;
            cyc(1);
            check("t6_alt_quiet", 32'(ped2), 32'h0);
            cyc(1);
            check("t6_alt_pulse", 32'(ped2),   32'h1);
            check("t6_alt_level", 32'(level2), 32'(din2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
